isp_ram_arb: RTL and testbench
==============================

// Module: isp_ram_arb
// PURPOSE
//  Owns the single-port program RAM shared by the ISP download writer and the Cortex-M0 bus.
//  While booting, the block grants the RAM to the ISP writer and holds the CPU in reset.
//  After the download completes (or when ISP is disabled), it drains, waits a settle delay,
//  then hands the RAM to the CPU and releases CPU reset. It also counts words and flags bad writes.
// PARAMETERS
//  AW          16     word address width (isp_addr, cpu_addr, ram_addr)
//  DW          32     data width
//  RAM_DEPTH   16384  valid words; any address >= RAM_DEPTH is out of range
//  RELEASE_DLY 16     cycles in DRAIN before entering RUN (>=1, max 65535)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   synchronous, active-high reset
//  isp_en      in   1   1 = perform download after reset; 0 = skip straight to DRAIN
//  isp_wr      in   1   one-cycle write strobe from ISP writer (no backpressure)
//  isp_addr    in   AW  ISP word address
//  isp_wdata   in   DW  ISP write data
//  dl_done     in   1   level; download finished (ISP idle timeout)
//  cpu_req     in   1   CPU access request
//  cpu_we      in   1   1 = write, 0 = read
//  cpu_addr    in   AW  CPU word address
//  cpu_wdata   in   DW  CPU write data
//  cpu_ready   out  1   access accepted this cycle
//  cpu_rvalid  out  1   read data valid (one cycle after accepted read)
//  cpu_rdata   out  DW  read data
//  ram_cs      out  1   RAM select
//  ram_we      out  1   RAM write enable
//  ram_addr    out  AW  RAM address
//  ram_wdata   out  DW  RAM write data
//  ram_rdata   in   DW  RAM read data, 1-cycle latency after ram_cs & !ram_we
//  cpu_rst_hold out 1   1 = keep CPU in reset
//  wr_count    out  16  accepted ISP writes, saturates at 16'hFFFF
//  isp_err     out  1   sticky: ISP write was dropped
//  isp_sum     out  DW  checksum (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: state=BOOT; cpu_rst_hold=1; ram_* / cpu_ready / cpu_rvalid / isp_err = 0;
//    wr_count=0; isp_sum=0; cpu_rdata=0. The delay counter is 0. Reset mid-operation aborts
//    everything in the same edge, including a pending cpu_rvalid.
//  FSM (2-bit): BOOT -> DRAIN when dl_done=1 or isp_en=0; DRAIN -> RUN when delay counter
//    reaches RELEASE_DLY-1; RUN is terminal until rst.
//  BOOT: the RAM port is combinationally driven from ISP. ram_cs=ram_we=isp_wr & in-range,
//    ram_addr=isp_addr, ram_wdata=isp_wdata.
//    - Accepted write: wr_count+1 on the next edge.
//    - Out-of-range write: no RAM access; isp_err is set.
//    - isp_wr in the same cycle as dl_done: the write is accepted, then the FSM moves to DRAIN.
//  DRAIN: ram_cs=0; the counter increments each cycle; cpu_rst_hold stays 1.
//    Any isp_wr is dropped and sets isp_err.
//  RUN: cpu_rst_hold=0 (registered, so it deasserts on the first RUN cycle).
//    - RAM port is combinationally driven from the CPU. ram_cs=cpu_req, ram_we=cpu_we,
//      addr and data pass through. cpu_ready=cpu_req.
//    - Accepted read: cpu_rvalid=1 and cpu_rdata=ram_rdata in the following cycle.
//      Back-to-back reads give one rvalid per cycle. cpu_rdata holds its value between reads.
//    - CPU out-of-range access: passes through unchecked (the bus decoder owns this).
//    - isp_wr in RUN: dropped, sets isp_err. ISP never preempts the CPU in RUN.
//  cpu_ready=0 in BOOT and DRAIN. A cpu_req made there is ignored, not queued.
//  Widths: wr_count saturates and never wraps. isp_sum wraps modulo 2^DW.
// CONFIGURATION
//  ISP_RAM_ARB_CKSUM_EN defined: isp_sum += isp_wdata on every accepted ISP write
//    (same edge as the wr_count update).
//  ISP_RAM_ARB_CKSUM_EN undefined: isp_sum is tied to 0 and no adder is built.
// TESTING
//  1 rst; isp_en=1; 3 writes to addrs 0,1,2 (data 11,22,33); dl_done=1
//    -> RAM holds the data; wr_count=3; isp_sum=66 (CKSUM_EN); rst_hold falls 1+RELEASE_DLY cycles later.
//  2 In BOOT, isp_wr addr=16384 -> no ram_cs; isp_err=1; wr_count unchanged.
//  3 isp_en=0 at reset -> DRAIN on the first cycle; RUN after RELEASE_DLY cycles;
//    cpu_req before RUN sees cpu_ready=0.
//  4 RUN: CPU writes addr 5=0xDEAD, then back-to-back reads of 5 and 0
//    -> rvalid on consecutive cycles with 0xDEAD, then 11.
//  5 isp_wr and dl_done in the same cycle -> write lands, wr_count+1; the next isp_wr sets isp_err.
//  6 rst asserted in RUN during a read -> next cycle cpu_rvalid=0, cpu_rst_hold=1, state=BOOT, counters 0.

Source files
------------

// File: rtl/isp_ram_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : isp_ram_arb_if                                             |
// | Description : CPU-side bus between the Cortex-M0 bus fabric and the      |
// |               program-RAM arbiter (isp_ram_arb).                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Signals                                                                  |
// |   cpu_req     master->slave  access request                              |
// |   cpu_we      master->slave  1 = write, 0 = read                         |
// |   cpu_addr    master->slave  word address (AW bits)                      |
// |   cpu_wdata   master->slave  write data (DW bits)                        |
// |   cpu_ready   slave->master  access accepted this cycle                  |
// |   cpu_rvalid  slave->master  read data valid, one cycle after accept     |
// |   cpu_rdata   slave->master  read data (DW bits)                         |
// | Modports                                                                 |
// |   master : CPU / bus fabric side                                         |
// |   slave  : arbiter side                                                  |
// +--------------------------------------------------------------------------+
interface isp_ram_arb_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ready;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rvalid, cpu_rdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rvalid, cpu_rdata
  );
endinterface
`default_nettype wire

// File: rtl/isp_ram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : isp_ram_arb                                                |
// | Description : Owner of the single-port program RAM shared by the ISP     |
// |               download writer and the Cortex-M0 bus. Grants the RAM to   |
// |               ISP during BOOT with the CPU held in reset, drains for     |
// |               RELEASE_DLY cycles, then hands the RAM to the CPU (RUN)    |
// |               and releases CPU reset. Counts accepted ISP writes and     |
// |               flags dropped ones.                                        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   AW          word address width                                         |
// |   DW          data width                                                 |
// |   RAM_DEPTH   number of valid words; addresses >= RAM_DEPTH out of range |
// |   RELEASE_DLY cycles spent in DRAIN before RUN (1..65535)                |
// | Build option                                                             |
// |   ISP_RAM_ARB_CKSUM_EN : when defined, isp_sum accumulates the data of   |
// |                          every accepted ISP write (mod 2^DW); otherwise |
// |                          isp_sum is tied to 0.                           |
// | Ports                                                                    |
// |   clk, rst      clock, synchronous active-high reset                     |
// |   isp_en        1 = run download after reset, 0 = go straight to DRAIN   |
// |   isp_wr        one-cycle ISP write strobe (no backpressure)             |
// |   isp_addr      ISP word address                                         |
// |   isp_wdata     ISP write data                                           |
// |   dl_done       level, download finished                                 |
// |   cpu           CPU bus (isp_ram_arb_if.slave)                           |
// |   ram_cs/we     RAM select / write enable                                |
// |   ram_addr      RAM word address                                         |
// |   ram_wdata     RAM write data                                           |
// |   ram_rdata     RAM read data, 1-cycle latency                           |
// |   cpu_rst_hold  1 = keep CPU in reset                                    |
// |   wr_count      accepted ISP writes, saturating                          |
// |   isp_err       sticky, an ISP write was dropped                         |
// |   isp_sum       ISP data checksum                                        |
// +--------------------------------------------------------------------------+
module isp_ram_arb #(
  parameter int AW          = 16,
  parameter int DW          = 32,
  parameter int RAM_DEPTH   = 16384,
  parameter int RELEASE_DLY = 16
) (
  input  logic          clk,
  input  logic          rst,
  // ISP download side
  input  logic          isp_en,
  input  logic          isp_wr,
  input  logic [AW-1:0] isp_addr,
  input  logic [DW-1:0] isp_wdata,
  input  logic          dl_done,
  // CPU bus
  isp_ram_arb_if.slave  cpu,
  // RAM port
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  // Status
  output logic          cpu_rst_hold,
  output logic [15:0]   wr_count,
  output logic          isp_err,
  output logic [DW-1:0] isp_sum
);

  localparam logic [15:0] c_dly_last  = 16'(RELEASE_DLY - 1);
  localparam logic [15:0] c_count_max = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  logic [15:0]   r_dly_cnt;
  logic          r_cpu_rst_hold;
  logic          r_rvalid;
  logic [DW-1:0] r_rdata;
  logic [15:0]   r_wr_count;
  logic          r_isp_err;

  logic          w_isp_in_range;
  logic          w_isp_accept;
  logic          w_isp_drop;
  logic          w_run;
  logic          w_cpu_rd;

  // Range check is done at 32 bits so RAM_DEPTH == 2**AW works as well.
  assign w_isp_in_range = (32'(isp_addr) < 32'(RAM_DEPTH));
  assign w_isp_accept   = (r_state == ST_BOOT) && isp_wr && w_isp_in_range;
  // Anything that is not an accepted write is a dropped one: out-of-range
  // in BOOT, or any strobe once the download window has closed.
  assign w_isp_drop     = isp_wr && !w_isp_accept;
  assign w_run          = (r_state == ST_RUN);
  assign w_cpu_rd       = w_run && cpu.cpu_req && !cpu.cpu_we;

  // --------------------------------------------------------------------------
  // RAM port mux. Purely combinational so neither owner pays a cycle of
  // latency; forced idle while rst is high so nothing reaches the RAM during
  // a reset that lands mid-operation.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!rst) begin
      case (r_state)
        ST_BOOT: begin
          ram_cs    = isp_wr && w_isp_in_range;
          ram_we    = isp_wr && w_isp_in_range;
          ram_addr  = isp_addr;
          ram_wdata = isp_wdata;
        end
        ST_RUN: begin
          // CPU range errors are the bus decoder's business, pass through.
          ram_cs    = cpu.cpu_req;
          ram_we    = cpu.cpu_we;
          ram_addr  = cpu.cpu_addr;
          ram_wdata = cpu.cpu_wdata;
        end
        default: begin
          ram_cs    = 1'b0;
        end
      endcase
    end
  end

  // Requests outside RUN are simply not acknowledged; nothing is queued.
  assign cpu.cpu_ready  = w_run && cpu.cpu_req && !rst;
  assign cpu.cpu_rvalid = r_rvalid;
  // The RAM already returns data one cycle after the read, so present it
  // directly while rvalid is high and hold the last value in between.
  assign cpu.cpu_rdata  = r_rvalid ? ram_rdata : r_rdata;

  // --------------------------------------------------------------------------
  // Control FSM plus all registered status outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_BOOT;
      r_dly_cnt      <= 16'd0;
      r_cpu_rst_hold <= 1'b1;
      r_rvalid       <= 1'b0;
      r_rdata        <= '0;
      r_wr_count     <= 16'd0;
      r_isp_err      <= 1'b0;
    end else begin
      if (w_isp_accept && (r_wr_count != c_count_max)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
      if (w_isp_drop) begin
        r_isp_err <= 1'b1;
      end

      r_rvalid <= w_cpu_rd;
      if (r_rvalid) begin
        r_rdata <= ram_rdata;
      end

      case (r_state)
        ST_BOOT: begin
          // A write in the same cycle as dl_done is still accepted above,
          // because the state only changes on this edge.
          if (dl_done || !isp_en) begin
            r_state   <= ST_DRAIN;
            r_dly_cnt <= 16'd0;
          end
        end
        ST_DRAIN: begin
          if (r_dly_cnt == c_dly_last) begin
            r_state        <= ST_RUN;
            r_cpu_rst_hold <= 1'b0;
          end else begin
            r_dly_cnt <= r_dly_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          // Unused encoding: fall back to a safe, CPU-held state.
          r_state        <= ST_BOOT;
          r_cpu_rst_hold <= 1'b1;
        end
      endcase
    end
  end

  assign cpu_rst_hold = r_cpu_rst_hold;
  assign wr_count     = r_wr_count;
  assign isp_err      = r_isp_err;

`ifdef ISP_RAM_ARB_CKSUM_EN
  logic [DW-1:0] r_isp_sum;

  // Updated on the same edge as wr_count; wraps modulo 2^DW.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_isp_sum <= '0;
    end else if (w_isp_accept) begin
      r_isp_sum <= r_isp_sum + isp_wdata;
    end
  end

  assign isp_sum = r_isp_sum;
`else
  assign isp_sum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_isp_ram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_isp_ram_arb                                             |
// | Description : Directed self-checking bench for isp_ram_arb with a small  |
// |               1-cycle-latency RAM model.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_isp_ram_arb;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int DEP = 16384;
  localparam int DLY = 4;

`ifdef ISP_RAM_ARB_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          isp_en;
  logic          isp_wr;
  logic [AW-1:0] isp_addr;
  logic [DW-1:0] isp_wdata;
  logic          dl_done;
  logic          ram_cs;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          cpu_rst_hold;
  logic [15:0]   wr_count;
  logic          isp_err;
  logic [DW-1:0] isp_sum;

  int n_pass  = 0;
  int n_total = 0;

  isp_ram_arb_if #(.AW(AW), .DW(DW)) cpu_if ();

  isp_ram_arb #(
    .AW(AW), .DW(DW), .RAM_DEPTH(DEP), .RELEASE_DLY(DLY)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .isp_en       (isp_en),
    .isp_wr       (isp_wr),
    .isp_addr     (isp_addr),
    .isp_wdata    (isp_wdata),
    .dl_done      (dl_done),
    .cpu          (cpu_if),
    .ram_cs       (ram_cs),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .cpu_rst_hold (cpu_rst_hold),
    .wr_count     (wr_count),
    .isp_err      (isp_err),
    .isp_sum      (isp_sum)
  );

  always #5 clk = ~clk;

  // Small single-port RAM model, indexed by the low address bits.
  logic [DW-1:0] mem [0:63];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_addr[5:0]] <= ram_wdata;
      else        ram_rdata          <= mem[ram_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic req, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    cpu_if.cpu_req   = req;
    cpu_if.cpu_we    = we;
    cpu_if.cpu_addr  = a;
    cpu_if.cpu_wdata = d;
  endtask

  task automatic isp_drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    isp_wr    = wr;
    isp_addr  = a;
    isp_wdata = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; isp_en = 1'b1; dl_done = 1'b0;
    isp_drive(1'b0, '0, '0);
    cpu_drive(1'b0, 1'b0, '0, '0);
    step(); step();

    // Reset state
    chk("rst_hold",   32'(cpu_rst_hold),      32'd1);
    chk("rst_ram_cs", 32'(ram_cs),            32'd0);
    chk("rst_ready",  32'(cpu_if.cpu_ready),  32'd0);
    chk("rst_rvalid", 32'(cpu_if.cpu_rvalid), 32'd0);
    chk("rst_rdata",  cpu_if.cpu_rdata,       32'd0);
    chk("rst_err",    32'(isp_err),           32'd0);
    chk("rst_count",  32'(wr_count),          32'd0);
    chk("rst_sum",    isp_sum,                32'd0);

    // 1: three ISP writes in BOOT
    rst = 1'b0;
    isp_drive(1'b1, 16'd0, 32'd11); #1;
    chk("t1_cs",    32'(ram_cs),   32'd1);
    chk("t1_we",    32'(ram_we),   32'd1);
    chk("t1_wdata", ram_wdata,     32'd11);
    step();
    isp_drive(1'b1, 16'd1, 32'd22); step();
    isp_drive(1'b1, 16'd2, 32'd33); #1;
    chk("t1_addr",  32'(ram_addr), 32'd2);
    step();
    isp_drive(1'b0, '0, '0);
    chk("t1_count", 32'(wr_count), 32'd3);
    chk("t1_sum",   isp_sum,       CK ? 32'd66 : 32'd0);
    chk("t1_err",   32'(isp_err),  32'd0);

    // 2: out-of-range write dropped, last in-range address accepted
    isp_drive(1'b1, 16'd16384, 32'd99); #1;
    chk("t2_oor_cs", 32'(ram_cs), 32'd0);
    step();
    isp_drive(1'b0, '0, '0);
    chk("t2_err",   32'(isp_err),  32'd1);
    chk("t2_count", 32'(wr_count), 32'd3);
    isp_drive(1'b1, 16'd16383, 32'd1); #1;
    chk("t2_edge_cs", 32'(ram_cs), 32'd1);
    step();
    isp_drive(1'b0, '0, '0);
    chk("t2_edge_count", 32'(wr_count), 32'd4);
    chk("t2_edge_sum",   isp_sum,       CK ? 32'd67 : 32'd0);

    // Download done: CPU reset released 1+DLY edges later, CPU ignored meanwhile
    dl_done = 1'b1;
    cpu_drive(1'b1, 1'b0, 16'd0, '0);
    for (int i = 1; i <= DLY; i++) begin
      step();
      chk("t1_hold_drain",  32'(cpu_rst_hold),     32'd1);
      chk("t1_ready_drain", 32'(cpu_if.cpu_ready), 32'd0);
      chk("t1_cs_drain",    32'(ram_cs),           32'd0);
    end
    step();
    dl_done = 1'b0;
    chk("t1_hold_run", 32'(cpu_rst_hold), 32'd0);

    // 4: CPU write then back-to-back reads
    cpu_drive(1'b1, 1'b1, 16'd5, 32'hDEAD); #1;
    chk("t4_ready", 32'(cpu_if.cpu_ready), 32'd1);
    chk("t4_cs",    32'(ram_cs),           32'd1);
    chk("t4_we",    32'(ram_we),           32'd1);
    chk("t4_addr",  32'(ram_addr),         32'd5);
    chk("t4_wdata", ram_wdata,             32'hDEAD);
    step();
    cpu_drive(1'b1, 1'b0, 16'd5, '0); #1;
    chk("t4_rd_we", 32'(ram_we), 32'd0);
    step();
    cpu_drive(1'b1, 1'b0, 16'd0, '0); #1;
    chk("t4_rv0", 32'(cpu_if.cpu_rvalid), 32'd1);
    chk("t4_rd0", cpu_if.cpu_rdata,       32'hDEAD);
    step();
    cpu_drive(1'b1, 1'b0, 16'd2, '0); #1;
    chk("t4_rv1", 32'(cpu_if.cpu_rvalid), 32'd1);
    chk("t4_rd1", cpu_if.cpu_rdata,       32'd11);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0); #1;
    chk("t4_rv2", 32'(cpu_if.cpu_rvalid), 32'd1);
    chk("t4_rd2", cpu_if.cpu_rdata,       32'd33);
    step();
    chk("t4_rv_idle",  32'(cpu_if.cpu_rvalid), 32'd0);
    chk("t4_rd_hold",  cpu_if.cpu_rdata,       32'd33);

    // 6: reset in RUN during a read
    cpu_drive(1'b1, 1'b0, 16'd0, '0);
    rst = 1'b1;
    step();
    cpu_drive(1'b0, 1'b0, '0, '0);
    chk("t6_rvalid", 32'(cpu_if.cpu_rvalid), 32'd0);
    chk("t6_hold",   32'(cpu_rst_hold),      32'd1);
    chk("t6_ready",  32'(cpu_if.cpu_ready),  32'd0);
    chk("t6_count",  32'(wr_count),          32'd0);
    chk("t6_sum",    isp_sum,                32'd0);
    chk("t6_err",    32'(isp_err),           32'd0);
    chk("t6_rdata",  cpu_if.cpu_rdata,       32'd0);

    // 5: isp_wr together with dl_done lands; the next one is dropped
    rst = 1'b0;
    dl_done = 1'b1;
    isp_drive(1'b1, 16'd3, 32'd44); #1;
    chk("t5_cs", 32'(ram_cs), 32'd1);
    step();
    isp_drive(1'b1, 16'd4, 32'd55); #1;
    chk("t5_late_cs", 32'(ram_cs),   32'd0);
    chk("t5_count",   32'(wr_count), 32'd1);
    chk("t5_err0",    32'(isp_err),  32'd0);
    step();
    isp_drive(1'b0, '0, '0);
    dl_done = 1'b0;
    chk("t5_err1",   32'(isp_err),  32'd1);
    chk("t5_count2", 32'(wr_count), 32'd1);
    chk("t5_sum",    isp_sum,       CK ? 32'd44 : 32'd0);
    for (int i = 3; i <= DLY; i++) step();
    chk("t5_hold_drain", 32'(cpu_rst_hold), 32'd1);
    step();
    chk("t5_hold_run", 32'(cpu_rst_hold), 32'd0);
    // ISP in RUN never reaches the RAM
    isp_drive(1'b1, 16'd0, 32'd77); #1;
    chk("t5_run_isp_cs", 32'(ram_cs), 32'd0);
    step();
    isp_drive(1'b0, '0, '0);
    cpu_drive(1'b1, 1'b0, 16'd3, '0); step();
    cpu_drive(1'b1, 1'b0, 16'd4, '0); #1;
    chk("t5_rd3", cpu_if.cpu_rdata, 32'd44);
    step();
    cpu_drive(1'b1, 1'b0, 16'd0, '0); #1;
    chk("t5_rd4", cpu_if.cpu_rdata, 32'd0);
    step();
    cpu_drive(1'b0, 1'b0, '0, '0); #1;
    chk("t5_rd0", cpu_if.cpu_rdata, 32'd11);

    // 3: isp_en=0 skips the download
    rst = 1'b1; isp_en = 1'b0;
    step();
    rst = 1'b0;
    cpu_drive(1'b1, 1'b0, 16'd0, '0); #1;
    chk("t3_ready_boot", 32'(cpu_if.cpu_ready), 32'd0);
    for (int i = 1; i <= DLY; i++) begin
      step();
      isp_drive(1'b0, '0, '0);
      chk("t3_ready_drain", 32'(cpu_if.cpu_ready), 32'd0);
      chk("t3_hold_drain",  32'(cpu_rst_hold),     32'd1);
      if (i == 1) begin
        isp_drive(1'b1, 16'd7, 32'd5); #1;
        chk("t3_drain_isp_cs", 32'(ram_cs), 32'd0);
      end
    end
    step();
    chk("t3_hold_run",  32'(cpu_rst_hold),     32'd0);
    chk("t3_ready_run", 32'(cpu_if.cpu_ready), 32'd1);
    chk("t3_err",       32'(isp_err),          32'd1);
    chk("t3_count",     32'(wr_count),         32'd0);
    cpu_drive(1'b0, 1'b0, '0, '0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
